// File: rtl/sa_ctrl_if.sv
// Host-side row streams of sa_ctrl: job input rows and replayed result rows.
// Signal names are given from the controller's point of view.
interface sa_ctrl_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SIZE  = 4
);
  localparam int unsigned RW = SIZE * WIDTH;

  logic          i_in_vld;
  logic          o_in_rdy;
  logic [RW-1:0] i_in_row;
  logic          o_res_vld;
  logic          i_res_rdy;
  logic [RW-1:0] o_res_row;
  logic          o_res_last;

  // Controller side
  modport slave (
    input  i_in_vld, i_in_row, i_res_rdy,
    output o_in_rdy, o_res_vld, o_res_row, o_res_last
  );

  // Host / DMA side
  modport master (
    output i_in_vld, i_in_row, i_res_rdy,
    input  o_in_rdy, o_res_vld, o_res_row, o_res_last
  );
endinterface

// File: rtl/sa_ctrl.sv
// sa_ctrl: host-side initiator for the systolic array. Loads SIZE B rows
// (weights) then streams SIZE A rows into the array, captures the SIZE result
// rows and replays them on a valid/ready stream.
// Optional: define SA_CTRL_TIMEOUT_EN to add a DRAIN watchdog that aborts the
// job (sets o_err, returns to IDLE) after 4*SIZE cycles without a result row.
module sa_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SIZE  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sa_ctrl_if.slave                host,
  output logic                    o_sa_we,
  output logic                    o_sa_a_vld,
  output logic [SIZE*WIDTH-1:0]   o_sa_a_rows,
  output logic                    o_sa_c_vld,
  input  logic                    i_sa_c_vld,
  input  logic [SIZE*WIDTH-1:0]   i_sa_c_rows,
  output logic                    o_busy,
  output logic                    o_err
);
  localparam int unsigned RW = SIZE * WIDTH;
  localparam int unsigned CW = $clog2(SIZE) + 1;
  localparam int unsigned IW = (SIZE > 1) ? $clog2(SIZE) : 1;
`ifdef SA_CTRL_TIMEOUT_EN
  localparam int unsigned WD_LIM = 4 * SIZE;
  localparam int unsigned WW     = $clog2(WD_LIM) + 1;
`endif

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD_B, ST_LOAD_A, ST_DRAIN, ST_OUT} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_row_cnt, w_row_cnt_nxt;
  logic [CW-1:0] r_res_cnt, w_res_cnt_nxt;
  logic [CW-1:0] r_rd_ptr, w_rd_ptr_nxt, w_rd_ptr_inc;
  logic [RW-1:0] r_buf [SIZE];

  logic          r_in_rdy, w_in_rdy_nxt;
  logic          r_sa_we, w_sa_we_nxt;
  logic          r_sa_a_vld, w_sa_a_vld_nxt;
  logic          r_sa_c_vld, w_sa_c_vld_nxt;
  logic [RW-1:0] r_sa_a_rows, w_sa_a_rows_nxt;
  logic          r_res_vld, w_res_vld_nxt;
  logic [RW-1:0] r_res_row, w_res_row_nxt;
  logic          r_res_last, w_res_last_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_err, w_err_nxt;

  logic          w_accept, w_cap, w_to_out;
  logic [RW-1:0] w_buf0, w_rd_row;
`ifdef SA_CTRL_TIMEOUT_EN
  logic [WW-1:0] r_wd, w_wd_nxt;
`endif

  // Handshake, result-capture qualification and buffer read ports
  assign w_accept     = host.i_in_vld & r_in_rdy;
  assign w_cap        = i_sa_c_vld && ((r_state == ST_LOAD_A) || (r_state == ST_DRAIN))
                        && (r_res_cnt < CW'(SIZE));
  assign w_buf0       = (w_cap && (r_res_cnt == '0)) ? i_sa_c_rows : r_buf[0];
  assign w_rd_ptr_inc = r_rd_ptr + CW'(1);
  assign w_rd_row     = r_buf[w_rd_ptr_inc[IW-1:0]];

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_row_cnt_nxt   = r_row_cnt;
    w_res_cnt_nxt   = r_res_cnt + CW'(w_cap);
    w_rd_ptr_nxt    = r_rd_ptr;
    w_sa_we_nxt     = 1'b0;
    w_sa_a_vld_nxt  = 1'b0;
    w_sa_c_vld_nxt  = 1'b0;
    w_sa_a_rows_nxt = r_sa_a_rows;
    w_res_vld_nxt   = 1'b0;
    w_res_row_nxt   = r_res_row;
    w_res_last_nxt  = 1'b0;
    w_err_nxt       = r_err | (i_sa_c_vld & ~w_cap);
    w_to_out        = 1'b0;
`ifdef SA_CTRL_TIMEOUT_EN
    w_wd_nxt        = '0;
`endif
    case (r_state)
      ST_IDLE, ST_LOAD_B: begin
        if (w_accept) begin
          w_sa_we_nxt     = 1'b1;
          w_sa_a_vld_nxt  = 1'b1;
          w_sa_a_rows_nxt = host.i_in_row;
          if (r_row_cnt == CW'(SIZE - 1)) begin
            w_row_cnt_nxt = '0;
            w_state_nxt   = ST_LOAD_A;
          end else begin
            w_row_cnt_nxt = r_row_cnt + CW'(1);
            w_state_nxt   = ST_LOAD_B;
          end
        end
      end
      ST_LOAD_A: begin
        if (w_accept) begin
          w_sa_a_vld_nxt  = 1'b1;
          w_sa_c_vld_nxt  = 1'b1;
          w_sa_a_rows_nxt = host.i_in_row;
          if (r_row_cnt == CW'(SIZE - 1)) begin
            w_row_cnt_nxt = '0;
            if (w_res_cnt_nxt == CW'(SIZE)) w_to_out = 1'b1;
            else                            w_state_nxt = ST_DRAIN;
          end else begin
            w_row_cnt_nxt = r_row_cnt + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (w_res_cnt_nxt == CW'(SIZE)) w_to_out = 1'b1;
`ifdef SA_CTRL_TIMEOUT_EN
        else if (w_cap) w_wd_nxt = '0;
        else if (r_wd == WW'(WD_LIM - 1)) begin
          w_err_nxt     = 1'b1;
          w_state_nxt   = ST_IDLE;
          w_res_cnt_nxt = '0;
        end
        else w_wd_nxt = r_wd + WW'(1);
`endif
      end
      ST_OUT: begin
        w_res_vld_nxt  = 1'b1;
        w_res_last_nxt = r_res_last;
        if (host.i_res_rdy) begin
          if (r_rd_ptr == CW'(SIZE - 1)) begin
            w_state_nxt    = ST_IDLE;
            w_res_vld_nxt  = 1'b0;
            w_res_last_nxt = 1'b0;
            w_rd_ptr_nxt   = '0;
            w_res_cnt_nxt  = '0;
          end else begin
            w_rd_ptr_nxt   = w_rd_ptr_inc;
            w_res_row_nxt  = w_rd_row;
            w_res_last_nxt = (w_rd_ptr_inc == CW'(SIZE - 1));
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Entering OUT presents buffer row 0 (bypassed if it lands this cycle)
    if (w_to_out) begin
      w_state_nxt    = ST_OUT;
      w_rd_ptr_nxt   = '0;
      w_res_vld_nxt  = 1'b1;
      w_res_row_nxt  = w_buf0;
      w_res_last_nxt = (SIZE == 1);
    end
    w_in_rdy_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD_B) ||
                   (w_state_nxt == ST_LOAD_A);
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_row_cnt   <= '0;
      r_res_cnt   <= '0;
      r_rd_ptr    <= '0;
      r_in_rdy    <= 1'b0;
      r_sa_we     <= 1'b0;
      r_sa_a_vld  <= 1'b0;
      r_sa_c_vld  <= 1'b0;
      r_sa_a_rows <= '0;
      r_res_vld   <= 1'b0;
      r_res_row   <= '0;
      r_res_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
`ifdef SA_CTRL_TIMEOUT_EN
      r_wd        <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_row_cnt   <= w_row_cnt_nxt;
      r_res_cnt   <= w_res_cnt_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_in_rdy    <= w_in_rdy_nxt;
      r_sa_we     <= w_sa_we_nxt;
      r_sa_a_vld  <= w_sa_a_vld_nxt;
      r_sa_c_vld  <= w_sa_c_vld_nxt;
      r_sa_a_rows <= w_sa_a_rows_nxt;
      r_res_vld   <= w_res_vld_nxt;
      r_res_row   <= w_res_row_nxt;
      r_res_last  <= w_res_last_nxt;
      r_busy      <= w_busy_nxt;
      r_err       <= w_err_nxt;
`ifdef SA_CTRL_TIMEOUT_EN
      r_wd        <= w_wd_nxt;
`endif
    end
  end

  // Result buffer; contents need no reset
  always_ff @(posedge clk) begin
    if (w_cap) r_buf[r_res_cnt[IW-1:0]] <= i_sa_c_rows;
  end

  assign host.o_in_rdy   = r_in_rdy;
  assign host.o_res_vld  = r_res_vld;
  assign host.o_res_row  = r_res_row;
  assign host.o_res_last = r_res_last;
  assign o_sa_we         = r_sa_we;
  assign o_sa_a_vld      = r_sa_a_vld;
  assign o_sa_c_vld      = r_sa_c_vld;
  assign o_sa_a_rows     = r_sa_a_rows;
  assign o_busy          = r_busy;
  assign o_err           = r_err;
endmodule

// File: tb/tb_sa_ctrl.sv
// Testbench for sa_ctrl with a behavioural systolic-array model attached.
module tb_sa_ctrl;
  localparam int WIDTH = 16;
  localparam int SIZE  = 4;
  localparam int RW    = SIZE * WIDTH;
  localparam int LAT   = 3;
  localparam int TMO   = 200;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sa_ctrl_if #(.WIDTH(WIDTH), .SIZE(SIZE)) intf ();

  logic          sa_we, sa_a_vld, sa_c_vld, c_vld, busy, err;
  logic [RW-1:0] sa_a_rows, c_rows;

  sa_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host        (intf),
    .o_sa_we     (sa_we),
    .o_sa_a_vld  (sa_a_vld),
    .o_sa_a_rows (sa_a_rows),
    .o_sa_c_vld  (sa_c_vld),
    .i_sa_c_vld  (c_vld),
    .i_sa_c_rows (c_rows),
    .o_busy      (busy),
    .o_err       (err)
  );

  // Array model: stores B rows, returns A*B rows LAT cycles after each A row
  logic [RW-1:0] bmat [SIZE];
  logic          pv [LAT];
  logic [RW-1:0] pd [LAT];
  int            b_idx, a_seen;
  bit            spur = 1'b0;
  int            suppress = -1;

  function automatic logic [RW-1:0] mm(input logic [RW-1:0] a);
    logic [RW-1:0]    r;
    logic [WIDTH-1:0] acc;
    for (int j = 0; j < SIZE; j++) begin
      acc = '0;
      for (int k = 0; k < SIZE; k++)
        acc = acc + WIDTH'(a[k*WIDTH +: WIDTH] * bmat[k][j*WIDTH +: WIDTH]);
      r[j*WIDTH +: WIDTH] = acc;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_idx  <= 0;
      a_seen <= 0;
      for (int i = 0; i < LAT; i++) begin pv[i] <= 1'b0; pd[i] <= '0; end
    end else begin
      pv[0] <= sa_a_vld & sa_c_vld & ((suppress < 0) || (a_seen < suppress));
      pd[0] <= mm(sa_a_rows);
      for (int i = 1; i < LAT; i++) begin pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; end
      if (sa_a_vld & sa_we) begin
        bmat[b_idx] <= sa_a_rows;
        b_idx       <= (b_idx + 1) % SIZE;
        a_seen      <= 0;
      end
      if (sa_a_vld & sa_c_vld) a_seen <= a_seen + 1;
    end
  end
  assign c_vld  = pv[LAT-1] | spur;
  assign c_rows = pd[LAT-1];

  int            total = 0;
  int            bad   = 0;
  logic [RW-1:0] exp_q [$];

  function automatic logic [RW-1:0] a_row(input int seed, input int i);
    logic [RW-1:0] r;
    for (int j = 0; j < SIZE; j++) r[j*WIDTH +: WIDTH] = WIDTH'(seed + i*SIZE + j + 1);
    return r;
  endfunction

  function automatic logic [RW-1:0] b_row(input int scale, input int i);
    logic [RW-1:0] r;
    for (int j = 0; j < SIZE; j++) r[j*WIDTH +: WIDTH] = (i == j) ? WIDTH'(scale) : '0;
    return r;
  endfunction

  // Expected result for B = scale*I is scale*A, computed element-wise
  function automatic logic [RW-1:0] exp_row(input int seed, input int scale, input int i);
    logic [RW-1:0] r;
    for (int j = 0; j < SIZE; j++) r[j*WIDTH +: WIDTH] = WIDTH'(scale * (seed + i*SIZE + j + 1));
    return r;
  endfunction

  task automatic drive_row(input logic [RW-1:0] row, input bit is_b);
    int n;
    n = 0;
    intf.i_in_vld = 1'b1;
    intf.i_in_row = row;
    while (intf.o_in_rdy !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) begin
      total++; bad++;
      $display("FAIL in_accept_timeout: o_in_rdy=%b, required 1 within %0d cycles", intf.o_in_rdy, TMO);
      intf.i_in_vld = 1'b0;
      return;
    end
    @(negedge clk);
    intf.i_in_vld = 1'b0;
    total++;
    if ({sa_a_vld, sa_we, sa_c_vld, sa_a_rows} !== {1'b1, is_b, ~is_b, row}) begin
      bad++;
      $display("FAIL array_beat: vld/we/cvld=%b%b%b rows=%h, required 1%b%b rows=%h",
               sa_a_vld, sa_we, sa_c_vld, sa_a_rows, is_b, ~is_b, row);
    end
  endtask

  task automatic gap_cycle();
    @(negedge clk);
    total++;
    if ({sa_a_vld, sa_we, sa_c_vld} !== 3'b000) begin
      bad++;
      $display("FAIL gap_valids: vld/we/cvld=%b%b%b, required 000", sa_a_vld, sa_we, sa_c_vld);
    end
  endtask

  task automatic drive_job(input int seed, input int scale, input bit gaps);
    for (int i = 0; i < SIZE; i++) begin
      drive_row(b_row(scale, i), 1'b1);
      if (gaps) gap_cycle();
    end
    for (int i = 0; i < SIZE; i++) begin
      exp_q.push_back(exp_row(seed, scale, i));
      drive_row(a_row(seed, i), 1'b0);
      if (gaps) gap_cycle();
    end
  endtask

  task automatic collect_job(input int stall_row, input int stall_cycles);
    int            k, n, left;
    logic [RW-1:0] held, e;
    k = 0; n = 0; left = stall_cycles; held = '0;
    while (k < SIZE) begin
      @(negedge clk);
      n++;
      if (n > 2*TMO) begin
        total++; bad++;
        $display("FAIL res_timeout: got %0d rows, required %0d", k, SIZE);
        break;
      end
      if (intf.o_res_vld === 1'b1) begin
        total++;
        if (intf.o_in_rdy !== 1'b0) begin
          bad++; $display("FAIL in_rdy_during_out: o_in_rdy=%b, required 0", intf.o_in_rdy);
        end
        if (k == stall_row && left > 0) begin
          if (left == stall_cycles) held = intf.o_res_row;
          else begin
            total++;
            if (intf.o_res_row !== held) begin
              bad++; $display("FAIL stall_hold: row=%h, required %h", intf.o_res_row, held);
            end
          end
          intf.i_res_rdy = 1'b0;
          left--;
        end else begin
          intf.i_res_rdy = 1'b1;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          total++;
          if (intf.o_res_row !== e) begin
            bad++; $display("FAIL res_row%0d: row=%h, required %h", k, intf.o_res_row, e);
          end
          total++;
          if (intf.o_res_last !== 1'(k == SIZE - 1)) begin
            bad++; $display("FAIL res_last%0d: last=%b, required %b", k, intf.o_res_last, k == SIZE - 1);
          end
          k++;
        end
      end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || intf.o_res_vld !== 1'b0) begin
      bad++; $display("FAIL post_job: busy=%b res_vld=%b, required 0 0", busy, intf.o_res_vld);
    end
  endtask

  task automatic check_err(input string name, input logic want);
    total++;
    if (err !== want) begin bad++; $display("FAIL %s: o_err=%b, required %b", name, err, want); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({intf.o_in_rdy, intf.o_res_vld, intf.o_res_last, sa_we, sa_a_vld, sa_c_vld, busy, err} !== 8'h00) begin
      bad++; $display("FAIL reset_flags: %b%b%b%b%b%b%b%b, required 00000000", intf.o_in_rdy,
                      intf.o_res_vld, intf.o_res_last, sa_we, sa_a_vld, sa_c_vld, busy, err);
    end
    total++;
    if (sa_a_rows !== '0 || intf.o_res_row !== '0) begin
      bad++; $display("FAIL reset_rows: a_rows=%h res_row=%h, required 0", sa_a_rows, intf.o_res_row);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (intf.o_in_rdy !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_ready: rdy=%b busy=%b, required 1 0", intf.o_in_rdy, busy);
    end
  endtask

  task automatic test_basic();
    fork
      drive_job(0, 1, 1'b0);
      collect_job(-1, 0);
    join
    check_err("basic_err", 1'b0);
  endtask

  task automatic test_gaps_backpressure();
    fork
      drive_job(20, 2, 1'b1);
      collect_job(1, 3);
    join
    check_err("gaps_err", 1'b0);
  endtask

  task automatic test_back_to_back();
    fork
      begin drive_job(40, 1, 1'b0); drive_job(60, 3, 1'b0); end
      begin collect_job(-1, 0); collect_job(-1, 0); end
    join
    check_err("b2b_err", 1'b0);
  endtask

  task automatic test_reset_mid_job();
    for (int i = 0; i < SIZE; i++) drive_row(b_row(1, i), 1'b1);
    for (int i = 0; i < 2; i++) drive_row(a_row(0, i), 1'b0);
    intf.i_in_vld = 1'b1;
    intf.i_in_row = a_row(0, 2);
    @(posedge clk);
    #2;
    total++;
    if (sa_a_vld !== 1'b1 || sa_c_vld !== 1'b1) begin
      bad++; $display("FAIL mid_beat: a_vld=%b c_vld=%b, required 1 1", sa_a_vld, sa_c_vld);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({sa_a_vld, sa_c_vld, sa_we, intf.o_in_rdy, busy, intf.o_res_vld} !== 6'b0 || sa_a_rows !== '0) begin
      bad++; $display("FAIL async_reset: %b%b%b%b%b%b rows=%h, required all 0", sa_a_vld, sa_c_vld,
                      sa_we, intf.o_in_rdy, busy, intf.o_res_vld, sa_a_rows);
    end
    intf.i_in_vld = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fork
      drive_job(80, 1, 1'b0);
      collect_job(-1, 0);
    join
  endtask

  task automatic test_spurious();
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check_err("spur_err_set", 1'b1);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || intf.o_in_rdy !== 1'b1) begin
      bad++; $display("FAIL spur_idle: busy=%b rdy=%b, required 0 1", busy, intf.o_in_rdy);
    end
    fork
      drive_job(100, 1, 1'b0);
      collect_job(-1, 0);
    join
    check_err("spur_err_sticky", 1'b1);
  endtask

  task automatic test_watchdog();
    bit seen_vld;
    int n;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_err("wd_err_clear", 1'b0);
    suppress = 2;
    seen_vld = 1'b0;
    drive_job(120, 1, 1'b0);
`ifdef SA_CTRL_TIMEOUT_EN
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      @(negedge clk); n++;
      if (intf.o_res_vld === 1'b1) seen_vld = 1'b1;
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wd_idle: busy=%b, required 0", busy); end
    check_err("wd_err_set", 1'b1);
`else
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (intf.o_res_vld === 1'b1) seen_vld = 1'b1;
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL no_wd_busy: busy=%b, required 1", busy); end
    check_err("no_wd_err", 1'b0);
`endif
    total++;
    if (seen_vld) begin bad++; $display("FAIL wd_res_vld: o_res_vld seen=1, required 0"); end
    suppress = -1;
    exp_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    intf.i_in_vld  = 1'b0;
    intf.i_in_row  = '0;
    intf.i_res_rdy = 1'b1;
    test_reset();
    test_basic();
    test_gaps_backpressure();
    test_back_to_back();
    test_reset_mid_job();
    test_spurious();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end
endmodule
